// File: rtl/score_display_pkg.sv
// score_display_pkg
//   Shared types and constants for the score/high-score display controller.
//   state_e     : PLAY / OVER game state (encoding matches state_o).
//   bcd_digit_t : one BCD nibble.
//   bcd4_t      : four packed BCD nibbles, [0] = ones.
//   BCD_MAX     : saturation value of the 4-digit score.
package score_display_pkg;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_e;

    typedef logic [3:0] bcd_digit_t;
    typedef bcd_digit_t [3:0] bcd4_t;

    localparam bcd4_t BCD_MAX = 16'h9999;

endpackage

// File: rtl/bcd4_sat_inc.sv
// bcd4_sat_inc
//   Combinational 4-digit BCD increment that saturates at 9999.
//   a       : input value (4 BCD nibbles, [0] = ones)
//   y       : a + 1 in BCD, or a unchanged when a is 9999
//   carry_o : 1 when a is 9999, i.e. the increment would overflow
module bcd4_sat_inc
    import score_display_pkg::*;
(
    input  bcd4_t a,
    output bcd4_t y,
    output logic  carry_o
);

    // c[k] = an increment reaches digit k (every lower digit was 9).
    logic [4:0] c;
    bcd4_t      sum;

    assign c[0] = 1'b1;

    for (genvar g = 0; g < 4; g++) begin : g_dig
        logic wrap;
        assign wrap     = c[g] && (a[g] == 4'd9);
        assign c[g+1]   = wrap;
        assign sum[g]   = !c[g] ? a[g] : (wrap ? 4'd0 : a[g] + 4'd1);
    end

    assign carry_o = c[4];
    assign y       = c[4] ? a : sum;

endmodule

// File: rtl/score_display_ctrl.sv
// score_display_ctrl
//   Keeps a BCD score and high score, picks which one feeds the 4-digit
//   seven-segment driver, blanks leading zeros and blinks the final score
//   after game over.
//   clk_i, rst_ni        : clock, async active-low reset
//   game_rst_i           : pulse, clear score and return to PLAY
//   score_inc_i          : pulse, score + 1 (PLAY only, saturating)
//   game_over_i          : pulse, PLAY -> OVER and latch high score
//   show_high_i          : level, show high score while in PLAY
//   digitN_o / digitN_en_o : registered digit values and enables
//   score_o, high_o, state_o : the state registers themselves
module score_display_ctrl
    import score_display_pkg::*;
#(
    parameter int BLINK_CYCLES = 500
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        game_rst_i,
    input  logic        score_inc_i,
    input  logic        game_over_i,
    input  logic        show_high_i,
    output logic        digit0_en_o,
    output logic [3:0]  digit0_o,
    output logic        digit1_en_o,
    output logic [3:0]  digit1_o,
    output logic        digit2_en_o,
    output logic [3:0]  digit2_o,
    output logic        digit3_en_o,
    output logic [3:0]  digit3_o,
    output logic [15:0] score_o,
    output logic [15:0] high_o,
    output logic        state_o
);

    localparam int CNT_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

    state_e           state;
    bcd4_t            score, high;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_on;

    bcd4_t            score_inc_val;
    logic             score_sat;
    bcd4_t            score_next;

    bcd4_t            src;
    logic [3:0]       en_nx;
    bcd4_t            digit_q;
    logic [3:0]       en_q;

    bcd4_sat_inc u_inc (
        .a       (score),
        .y       (score_inc_val),
        .carry_o (score_sat)
    );

    // Score as it would be after this cycle's increment, used both for the
    // score register and for the high-score compare on game over.
    assign score_next = (score_inc_i && !score_sat) ? score_inc_val : score;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= PLAY;
            score     <= '0;
            high      <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (game_rst_i) begin
            state     <= PLAY;
            score     <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            case (state)
                PLAY: begin
                    score     <= score_next;
                    blink_cnt <= '0;
                    blink_on  <= 1'b1;
                    if (game_over_i) begin
                        state <= OVER;
                        if (score_next > high) high <= score_next;
                    end
                end
                OVER: begin
                    if (blink_cnt == CNT_LAST) begin
                        blink_cnt <= '0;
                        blink_on  <= ~blink_on;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
                default: state <= PLAY;
            endcase
        end
    end

    // Display source and leading-zero blanking: digit k lights when any
    // nibble at or above k is nonzero; the ones digit always lights.
    assign src = (state == PLAY && show_high_i) ? high : score;

    assign en_nx[0] = 1'b1;
    for (genvar k = 1; k < 4; k++) begin : g_blank
        assign en_nx[k] = |src[3:k];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            digit_q <= '0;
            en_q    <= 4'b0001;
        end else begin
            digit_q <= src;
            en_q    <= (state == OVER && !blink_on) ? 4'b0000 : en_nx;
        end
    end

    assign digit0_o    = digit_q[0];
    assign digit1_o    = digit_q[1];
    assign digit2_o    = digit_q[2];
    assign digit3_o    = digit_q[3];
    assign digit0_en_o = en_q[0];
    assign digit1_en_o = en_q[1];
    assign digit2_en_o = en_q[2];
    assign digit3_en_o = en_q[3];

    assign score_o = score;
    assign high_o  = high;
    assign state_o = state;

endmodule

// File: tb/tb_score_display_ctrl.sv
module tb_score_display_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        game_rst_i = 1'b0;
    logic        score_inc_i = 1'b0;
    logic        game_over_i = 1'b0;
    logic        show_high_i = 1'b0;
    logic        digit0_en_o, digit1_en_o, digit2_en_o, digit3_en_o;
    logic [3:0]  digit0_o, digit1_o, digit2_o, digit3_o;
    logic [15:0] score_o, high_o;
    logic        state_o;

    int n_checks = 0;
    int n_fail   = 0;

    score_display_ctrl #(.BLINK_CYCLES(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .game_rst_i  (game_rst_i),
        .score_inc_i (score_inc_i),
        .game_over_i (game_over_i),
        .show_high_i (show_high_i),
        .digit0_en_o (digit0_en_o),
        .digit0_o    (digit0_o),
        .digit1_en_o (digit1_en_o),
        .digit1_o    (digit1_o),
        .digit2_en_o (digit2_en_o),
        .digit2_o    (digit2_o),
        .digit3_en_o (digit3_en_o),
        .digit3_o    (digit3_o),
        .score_o     (score_o),
        .high_o      (high_o),
        .state_o     (state_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic inc_n(input int n);
        score_inc_i = 1'b1;
        repeat (n) step();
        score_inc_i = 1'b0;
    endtask

    task automatic pulse_rst();
        game_rst_i = 1'b1;
        step();
        game_rst_i = 1'b0;
    endtask

    task automatic pulse_over();
        game_over_i = 1'b1;
        step();
        game_over_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] en;
        en = {digit3_en_o, digit2_en_o, digit1_en_o, digit0_en_o};
        n_checks++;
        if (en !== 4'b0001) begin
            n_fail++; $display("FAIL reset_en got %b want 0001", en);
        end
        n_checks++;
        if (digit0_o !== 4'd0) begin
            n_fail++; $display("FAIL reset_digit0 got %h want 0", digit0_o);
        end
        n_checks++;
        if (score_o !== 16'h0000 || high_o !== 16'h0000 || state_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_state got score=%h high=%h state=%b want 0000 0000 0", score_o, high_o, state_o);
        end
    endtask

    task automatic test_count();
        logic [3:0] en;
        inc_n(10);
        step();
        en = {digit3_en_o, digit2_en_o, digit1_en_o, digit0_en_o};
        n_checks++;
        if (score_o !== 16'h0010) begin
            n_fail++; $display("FAIL count10_score got %h want 0010", score_o);
        end
        n_checks++;
        if (en !== 4'b0011 || digit1_o !== 4'd1 || digit0_o !== 4'd0) begin
            n_fail++; $display("FAIL count10_digits got en=%b d1=%h d0=%h want 0011 1 0", en, digit1_o, digit0_o);
        end
        inc_n(999);
        step();
        en = {digit3_en_o, digit2_en_o, digit1_en_o, digit0_en_o};
        n_checks++;
        if (score_o !== 16'h1009) begin
            n_fail++; $display("FAIL count1009_score got %h want 1009", score_o);
        end
        n_checks++;
        if (en !== 4'b1111 || {digit3_o, digit2_o, digit1_o, digit0_o} !== 16'h1009) begin
            n_fail++; $display("FAIL count1009_digits got en=%b d=%h%h%h%h want 1111 1009", en, digit3_o, digit2_o, digit1_o, digit0_o);
        end
    endtask

    task automatic test_saturate();
        inc_n(8989);
        n_checks++;
        if (score_o !== 16'h9998) begin
            n_fail++; $display("FAIL sat_preload got %h want 9998", score_o);
        end
        inc_n(3);
        step();
        n_checks++;
        if (score_o !== 16'h9999) begin
            n_fail++; $display("FAIL sat_hold got %h want 9999", score_o);
        end
        n_checks++;
        if ({digit3_o, digit2_o, digit1_o, digit0_o} !== 16'h9999) begin
            n_fail++; $display("FAIL sat_digits got %h%h%h%h want 9999", digit3_o, digit2_o, digit1_o, digit0_o);
        end
    endtask

    task automatic test_high_update();
        pulse_rst();
        n_checks++;
        if (score_o !== 16'h0000 || state_o !== 1'b0 || high_o !== 16'h0000) begin
            n_fail++; $display("FAIL game_rst got score=%h state=%b high=%h want 0000 0 0000", score_o, state_o, high_o);
        end
        inc_n(42);
        score_inc_i = 1'b1;
        game_over_i = 1'b1;
        step();
        score_inc_i = 1'b0;
        game_over_i = 1'b0;
        n_checks++;
        if (high_o !== 16'h0043 || state_o !== 1'b1 || score_o !== 16'h0043) begin
            n_fail++; $display("FAIL over_coinc got high=%h state=%b score=%h want 0043 1 0043", high_o, state_o, score_o);
        end
        inc_n(3);
        pulse_over();
        n_checks++;
        if (score_o !== 16'h0043 || high_o !== 16'h0043 || state_o !== 1'b1) begin
            n_fail++; $display("FAIL over_ignore got score=%h high=%h state=%b want 0043 0043 1", score_o, high_o, state_o);
        end
        pulse_rst();
        inc_n(5);
        pulse_over();
        n_checks++;
        if (high_o !== 16'h0043 || score_o !== 16'h0005 || state_o !== 1'b1) begin
            n_fail++; $display("FAIL high_keep got high=%h score=%h state=%b want 0043 0005 1", high_o, score_o, state_o);
        end
    endtask

    task automatic test_blink();
        logic exp_en;
        pulse_rst();
        inc_n(7);
        show_high_i = 1'b1;     // must be ignored in OVER
        pulse_over();
        for (int i = 0; i < 12; i++) begin
            step();
            exp_en = (i < 4) || (i >= 8);
            n_checks++;
            if (digit0_en_o !== exp_en || digit0_o !== 4'd7) begin
                n_fail++; $display("FAIL blink cyc%0d got en0=%b d0=%h want %b 7", i, digit0_en_o, digit0_o, exp_en);
            end
        end
        show_high_i = 1'b0;
        game_rst_i  = 1'b1;
        game_over_i = 1'b1;
        step();
        game_rst_i  = 1'b0;
        game_over_i = 1'b0;
        n_checks++;
        if (state_o !== 1'b0 || score_o !== 16'h0000) begin
            n_fail++; $display("FAIL rst_over_prio got state=%b score=%h want 0 0000", state_o, score_o);
        end
    endtask

    task automatic test_show_high();
        logic [3:0] en;
        inc_n(120);
        pulse_over();
        n_checks++;
        if (high_o !== 16'h0120) begin
            n_fail++; $display("FAIL high_120 got %h want 0120", high_o);
        end
        pulse_rst();
        inc_n(5);
        show_high_i = 1'b1;
        step();
        en = {digit3_en_o, digit2_en_o, digit1_en_o, digit0_en_o};
        n_checks++;
        if (en !== 4'b0111 || {digit2_o, digit1_o, digit0_o} !== 12'h120) begin
            n_fail++; $display("FAIL show_high got en=%b d=%h%h%h want 0111 120", en, digit2_o, digit1_o, digit0_o);
        end
        show_high_i = 1'b0;
        step();
        en = {digit3_en_o, digit2_en_o, digit1_en_o, digit0_en_o};
        n_checks++;
        if (en !== 4'b0001 || digit0_o !== 4'd5) begin
            n_fail++; $display("FAIL show_score got en=%b d0=%h want 0001 5", en, digit0_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] en;
        inc_n(30);
        #2;
        rst_ni = 1'b0;
        #1;
        en = {digit3_en_o, digit2_en_o, digit1_en_o, digit0_en_o};
        n_checks++;
        if (high_o !== 16'h0000 || score_o !== 16'h0000 || state_o !== 1'b0 || en !== 4'b0001 || digit0_o !== 4'd0) begin
            n_fail++; $display("FAIL reset_mid got high=%h score=%h state=%b en=%b d0=%h want 0000 0000 0 0001 0", high_o, score_o, state_o, en, digit0_o);
        end
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        repeat (2) step();
        rst_ni = 1'b1;
        step();
        test_reset();
        test_count();
        test_saturate();
        test_high_update();
        test_blink();
        test_show_high();
        test_reset_mid();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Game-side controller for the Basys3 4-digit seven-segment path.
- Keeps a 4-digit BCD score and a BCD high score, and arbitrates which of the two is shown.
- Applies leading-zero blanking and blinks the final score after game over.
- Drives the digit value/enable inputs of the multiplexing 7-seg driver directly.

Parameters:
- BLINK_CYCLES, default 500: clk_i cycles per blink half-period in OVER state (500 at 1 kHz gives 1 Hz blink); legal range 2 or more.

Ports:
- clk_i  input  1  system clock, rising-edge.
- rst_ni  input  1  asynchronous active-low reset.
- game_rst_i  input  1  synchronous one-cycle pulse; clears score, returns to PLAY.
- score_inc_i  input  1  one-cycle pulse; score +1.
- game_over_i  input  1  one-cycle pulse; end of run.
- show_high_i  input  1  level; in PLAY, selects high score for display.
- digit0_en_o  output  1  enable, least-significant digit.
- digit0_o  output  4  BCD value, least-significant digit.
- digit1_en_o / digit1_o  output  1 / 4  digit 1 enable and value.
- digit2_en_o / digit2_o  output  1 / 4  digit 2 enable and value.
- digit3_en_o / digit3_o  output  1 / 4  digit 3 enable and value.
- score_o  output  16  current score, 4 BCD nibbles, [3:0] = ones.
- high_o  output  16  high score, 4 BCD nibbles.
- state_o  output  1  0 = PLAY, 1 = OVER.

Behaviour:
- Reset (async assert, sync-to-clock deassert externally) clears the following:
  - state = PLAY, score = 0, high = 0, blink counter = 0, blink phase = on.
  - All digitN_o = 0; digit0_en_o = 1; digit1..3_en_o = 0.
- Score counter (PLAY only):
  - score_inc_i increments BCD with decimal carry between nibbles; 0009 -> 0010, 0999 -> 1000.
  - Saturates at 9999; a further increment holds 9999 and never wraps.
  - In OVER, score_inc_i is ignored.
- Events are priority-ordered, same cycle: game_rst_i > game_over_i > score_inc_i.
  - game_rst_i: score <= 0, state <= PLAY, blink counter/phase reset; high unchanged; other inputs that cycle ignored.
  - game_over_i in PLAY: state <= OVER; high <= max(high, score_next), where score_next includes a coincident score_inc_i. BCD nibbles compare as an unsigned 16-bit value.
  - game_over_i in OVER: ignored (no second high update).
- State machine: PLAY -> OVER on game_over_i; OVER -> PLAY only on game_rst_i.
- Display source:
  - PLAY: high if show_high_i else score.
  - OVER: always score; show_high_i is ignored.
- Leading-zero blanking:
  - digitK_en = 1 iff some nibble at position >= K of the source is nonzero.
  - digit0_en is always 1 (value 0 shows "0").
- Blink (OVER only):
  - Counter counts 0..BLINK_CYCLES-1, then wraps and toggles the phase.
  - Phase starts "on" on entry to OVER.
  - Off phase forces all four digitK_en = 0; digit values stay driven.
  - Counter and phase are held reset in PLAY.
- Latency: all digit outputs registered, updating 1 cycle after the score/high/state/select change that causes them. score_o, high_o and state_o are the state registers themselves.
- Reset mid-operation: outputs return to reset values immediately; high score is lost (not retained).

Decomposition:
- Package score_display_pkg:
  - state enum (PLAY, OVER).
  - bcd_digit_t (logic [3:0]).
  - bcd4_t (4 x bcd_digit_t, packed).
  - Constant BCD_MAX = 16'h9999.
- Sub-module bcd4_sat_inc: combinational 4-digit BCD +1 with saturation at 9999, plus a carry-out flag.
- Blanking and compare logic stay inline.

Test Plan:
- Reset then idle: digit0_en_o=1, others 0, digit0_o=0, score_o=0, high_o=0, state_o=0.
- 10 score_inc_i pulses: score_o=16'h0010, digit1_en_o=1, digit1_o=1, digit2/3_en_o=0; 999 more pulses: score_o=16'h1009, all enables 1.
- Preload score 9998, 3 pulses: score_o saturates at 16'h9999, no wrap.
- score 0042, coincident score_inc_i + game_over_i: high_o=16'h0043, state_o=1. Then game_rst_i, 5 increments, game_over_i: high_o stays 16'h0043.
- OVER with BLINK_CYCLES=4, score 0007: digit0_en_o reads 1 for 4 cycles, 0 for 4, 1 for 4 (one-cycle register lag). Coincident game_rst_i + game_over_i: rst wins, state_o=0, score_o=0.
- PLAY with high=0120, score=0005, show_high_i=1: digit outputs 0,2,1 with en 1,1,1,0. Deassert show_high_i: next cycle digit0_o=5, only digit0_en_o=1.
